hyper_clk_divider: RTL and testbench

HYPER_CLK_DIVIDER -- requirements
Module: hyper_clk_divider

---
 rtl/hyper_clk_pkg.sv | 12 +
 rtl/hyper_clk_div_cnt.sv | 53 +++++
 rtl/tc_clk_gating.sv | 19 +
 rtl/tc_clk_mux2.sv | 11 +
 rtl/hyper_clk_divider.sv | 103 ++++++++++
 tb/tb_hyper_clk_divider.sv | 216 +++++++++++++++++++++
 6 files changed

// File: rtl/hyper_clk_pkg.sv
// Shared types and defaults for the glitch-free runtime-programmable clock divider.
package hyper_clk_pkg;

    localparam int unsigned DIV_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2
    } state_e;

endpackage

// File: rtl/hyper_clk_div_cnt.sv
// Period counter and divided-clock flop: high for ceil(D/2) counts, low for the rest.
module hyper_clk_div_cnt
    import hyper_clk_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    output logic                 wrap_o,
    output logic                 clk_div_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] high_len;
    logic                 clk_div_q, clk_div_d;
    logic                 divide;

    assign divide   = (div_i >= DIV_WIDTH'(2));
    assign high_len = (div_i >> 1) + DIV_WIDTH'(div_i[0]);
    assign wrap_o   = divide && (cnt_q == div_i - DIV_WIDTH'(1));

    always_comb begin
        cnt_d     = cnt_q + DIV_WIDTH'(1);
        if (!divide || wrap_o) begin
            cnt_d = '0;
        end
        clk_div_d = divide && (cnt_d < high_len);
        if (clear_i) begin
            cnt_d     = '0;
            clk_div_d = 1'b0;
        end else if (start_i) begin
            // Restart with the high phase beginning in the very next cycle.
            cnt_d     = '0;
            clk_div_d = divide;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            clk_div_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign clk_div_o = clk_div_q;

endmodule

// File: rtl/tc_clk_gating.sv
// Latch-based clock gate: the enable is captured only while the clock is low.
module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch;

    always_latch begin
        if (!clk_i) begin
            en_latch <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/tc_clk_mux2.sv
// Clock multiplexer cell: clk0_i when sel is low, clk1_i when sel is high.
module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);

    assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// File: rtl/hyper_clk_divider.sv
// Runtime-programmable clock divider; divider changes drain the old period and
// switch the output mux only while the gate is closed.
module hyper_clk_divider
    import hyper_clk_pkg::*;
#(
    parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  logic                 en_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 clk_o
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

    state_e               state_q;
    logic                 gated_second_q;
    logic [DIV_WIDTH-1:0] div_q, div_pend_q;
    logic                 ready_q, gate_open_q, bypass_q;
    logic                 wrap, clk_div, drain_done, cnt_clear, cnt_start;
    logic                 clk_mux;

    assign drain_done = wrap || bypass_q;
    assign cnt_clear  = ((state_q == DRAIN) && drain_done) ||
                        ((state_q == GATED) && !gated_second_q);
    assign cnt_start  = (state_q == GATED) && gated_second_q;

    hyper_clk_div_cnt #(.DIV_WIDTH(DIV_WIDTH)) u_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .div_i     (div_q),
        .clear_i   (cnt_clear),
        .start_i   (cnt_start),
        .wrap_o    (wrap),
        .clk_div_o (clk_div)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= RUN;
            gated_second_q <= 1'b0;
            div_q          <= DEF_DIV;
            div_pend_q     <= DEF_DIV;
            ready_q        <= 1'b0;
            gate_open_q    <= 1'b0;
            bypass_q       <= (DEF_DIV < DIV_WIDTH'(2));
        end else begin
            case (state_q)
                RUN: begin
                    ready_q     <= 1'b1;
                    gate_open_q <= 1'b1;
                    if (div_valid_i && ready_q) begin
                        div_pend_q  <= div_i;
                        state_q     <= DRAIN;
                        ready_q     <= 1'b0;
                        gate_open_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q        <= GATED;
                        gated_second_q <= 1'b0;
                        div_q          <= div_pend_q;
                        bypass_q       <= (div_pend_q < DIV_WIDTH'(2));
                    end
                end
                GATED: begin
                    // Arm the latch in the last quiet cycle so the first new high phase passes whole.
                    if (!gated_second_q) begin
                        gated_second_q <= 1'b1;
                        gate_open_q    <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign div_ready_o = ready_q;

    tc_clk_mux2 u_clk_mux (
        .clk0_i    (clk_div),
        .clk1_i    (clk_i),
        .clk_sel_i (bypass_q | test_mode_i),
        .clk_o     (clk_mux)
    );

    tc_clk_gating u_clk_gate (
        .clk_i     (clk_mux),
        .en_i      (en_i & gate_open_q),
        .test_en_i (test_mode_i),
        .clk_o     (clk_o)
    );

endmodule

// File: tb/tb_hyper_clk_divider.sv
// Self-checking bench: directed divider switches plus random traffic against a period-level model.
module tb_hyper_clk_divider;

    localparam int W    = 8;
    localparam int DEF  = 1;
    localparam int HALF = 5;

    logic         clk_i       = 1'b0;
    logic         rst_ni      = 1'b0;
    logic         test_mode_i = 1'b0;
    logic         en_i        = 1'b1;
    logic         div_valid_i = 1'b0;
    logic [W-1:0] div_i       = '0;
    logic         div_ready_o;
    logic         clk_o;

    int vectors     = 0;
    int miscompares = 0;

    bit en_s   = 1'b1;
    bit test_s = 1'b0;

    // Reference model: current/pending divide ratio, position within the period,
    // whether a switch is draining, and how many quiet cycles remain.
    int m_cur, m_pend, m_pos, m_gated_left;
    bit m_switching, m_fresh;
    bit m_latch = 1'b0;

    time t_last = 0;

    hyper_clk_divider #(.DIV_WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .test_mode_i (test_mode_i),
        .en_i        (en_i),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .div_i       (div_i),
        .clk_o       (clk_o)
    );

    always #HALF clk_i = ~clk_i;

    function automatic bit m_ready();
        return !m_fresh && !m_switching && (m_gated_left == 0);
    endfunction

    function automatic bit m_gate();
        return !m_fresh && !m_switching && (m_gated_left != 2);
    endfunction

    function automatic bit m_div_high();
        return !m_fresh && (m_gated_left == 0) && (m_cur >= 2) && (m_pos < (m_cur + 1) / 2);
    endfunction

    task automatic m_reset();
        m_cur        = DEF;
        m_pend       = DEF;
        m_pos        = 0;
        m_gated_left = 0;
        m_switching  = 1'b0;
        m_fresh      = 1'b1;
    endtask

    task automatic m_edge(input bit v, input int d);
        if (m_gated_left > 0) begin
            m_gated_left--;
            m_pos = 0;
        end else if (m_switching && (m_cur < 2 || m_pos == m_cur - 1)) begin
            m_switching  = 1'b0;
            m_gated_left = 2;
            m_cur        = m_pend;
            m_pos        = 0;
        end else begin
            if (v && m_ready()) begin
                m_switching = 1'b1;
                m_pend      = d;
            end
            m_pos = (m_cur < 2) ? 0 : (m_pos + 1) % m_cur;
        end
        m_fresh = 1'b0;
    endtask

    task automatic check(input bit high_half);
        bit sel, mux, exp_clk, exp_rdy;
        sel = test_mode_i || (m_cur < 2);
        mux = sel ? high_half : m_div_high();
        if (!mux) m_latch = (en_i && m_gate()) || test_mode_i;
        exp_clk = mux && m_latch;
        exp_rdy = m_ready();
        vectors++;
        assert (clk_o === exp_clk) else begin
            miscompares++;
            $error("FAIL clk_o_%s: got %0b expected %0b (D=%0d pos=%0d t=%0t)",
                   high_half ? "hi" : "lo", clk_o, exp_clk, m_cur, m_pos, $time);
        end
        vectors++;
        assert (div_ready_o === exp_rdy) else begin
            miscompares++;
            $error("FAIL div_ready_o: got %0b expected %0b (t=%0t)", div_ready_o, exp_rdy, $time);
        end
    endtask

    task automatic step(input bit v, input int d, input bit rst);
        @(negedge clk_i);
        #1;
        div_valid_i = v;
        div_i       = d[W-1:0];
        en_i        = en_s;
        rst_ni      = rst;
        if (test_s != test_mode_i && !m_div_high()) test_mode_i = test_s;
        if (!rst) m_reset();
        #2 check(1'b0);
        @(posedge clk_i);
        if (rst_ni) m_edge(v, d);
        #2 check(1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1);
    endtask

    task automatic handshake(input int d);
        int guard;
        guard = 0;
        while (!m_ready() && guard < 64) begin
            step(1'b0, 0, 1'b1);
            guard++;
        end
        vectors++;
        assert (guard < 64) else begin
            miscompares++;
            $error("FAIL ready_timeout: waited %0d cycles, limit 64", guard);
        end
        step(1'b1, d, 1'b1);
    endtask

    // Pulse-width monitor: no high or low phase of clk_o may be shorter than half a source period.
    always @(clk_o) begin
        if (t_last != 0) begin
            vectors++;
            assert ($time - t_last >= HALF) else begin
                miscompares++;
                $error("FAIL glitch: clk_o phase width %0t, minimum %0d", $time - t_last, HALF);
            end
        end
        t_last = $time;
    end

    initial begin
        int guard;
        bit v;
        int d;
        m_reset();

        repeat (3) step(1'b0, 0, 1'b0);
        idle(6);

        handshake(4);
        idle(14);
        handshake(5);
        idle(16);
        handshake(3);
        idle(10);
        handshake(0);
        idle(6);
        handshake(6);
        idle(16);
        handshake(6);
        idle(14);

        handshake(4);
        idle(6);
        en_s = 1'b0;
        idle(7);
        en_s = 1'b1;
        idle(12);

        handshake(9);
        guard = 0;
        while (m_gated_left == 0 && guard < 64) begin
            step(1'b0, 0, 1'b1);
            guard++;
        end
        vectors++;
        assert (guard < 64) else begin
            miscompares++;
            $error("FAIL gated_timeout: waited %0d cycles, limit 64", guard);
        end
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        idle(6);

        handshake(6);
        idle(8);
        test_s = 1'b1;
        idle(10);
        handshake(3);
        idle(10);
        test_s = 1'b0;
        idle(12);

        for (int i = 0; i < 1500; i++) begin
            v    = ($urandom_range(0, 5) == 0);
            d    = $urandom_range(0, 9);
            en_s = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) test_s = !test_s;
            if ($urandom_range(0, 299) == 0) step(1'b0, 0, 1'b0);
            step(v, d, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
